// File: rtl/ext_ram_reader.sv
// Read-side master for a 4-bit serial external RAM: serialises command and address
// nibbles, waits the fixed read latency, then reassembles returned nibbles into words.
module ext_ram_reader #(
  parameter int READ_LATENCY = 10,
  parameter int GAP_CYCLES   = 2,
  parameter int MAX_LEN_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [15:0]             req_addr,
  input  logic [MAX_LEN_BITS-1:0] req_len,
  input  logic                    abort,
  output logic [3:0]              addr_pins,
  input  logic [3:0]              data_pins,
  output logic                    out_valid,
  output logic [15:0]             out_data,
  output logic [15:0]             out_addr,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [3:0] CMD_READ = 4'h1;

  // One counter serves the address-nibble index, the latency wait and the gap.
  localparam int CNT_MAX_A = (READ_LATENCY > GAP_CYCLES) ? READ_LATENCY : GAP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > 4) ? CNT_MAX_A : 4;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_GAP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [15:0]             addr_q;
  logic [15:0]             word_addr;
  logic [MAX_LEN_BITS-1:0] len_q;
  logic [MAX_LEN_BITS-1:0] word_idx;
  logic [1:0]              nib_cnt;
  logic [11:0]             shreg;
  logic [3:0]              addr_nibble;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    addr_nibble = addr_q[3:0];
    case (cnt[1:0])
      2'd0:    addr_nibble = addr_q[15:12];
      2'd1:    addr_nibble = addr_q[11:8];
      2'd2:    addr_nibble = addr_q[7:4];
      default: addr_nibble = addr_q[3:0];
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  // NOTE: the datapath registers are reset too, so a burst cut by rst_n leaves no stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      word_addr <= '0;
      len_q     <= '0;
      word_idx  <= '0;
      nib_cnt   <= '0;
      shreg     <= '0;
      addr_pins <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            word_addr <= req_addr;
            len_q     <= req_len;
            word_idx  <= '0;
            nib_cnt   <= '0;
            cnt       <= '0;
            addr_pins <= CMD_READ;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CMD;
          end
        end

        S_CMD: begin
          if (abort) begin
            addr_pins <= '0;
            cnt       <= CNT_W'(GAP_CYCLES - 1);
            state     <= S_GAP;
          end else begin
            addr_pins <= addr_nibble;
            cnt       <= CNT_W'(1);
            state     <= S_ADDR;
          end
        end

        // cnt counts nibbles already on the pins; the fourth one occupies the last ADDR cycle.
        S_ADDR: begin
          if (abort) begin
            addr_pins <= '0;
            cnt       <= CNT_W'(GAP_CYCLES - 1);
            state     <= S_GAP;
          end else if (cnt != CNT_W'(4)) begin
            addr_pins <= addr_nibble;
            cnt       <= cnt + 1'b1;
          end else begin
            addr_pins <= '0;
            if (READ_LATENCY > 1) begin
              cnt   <= CNT_W'(READ_LATENCY - 2);
              state <= S_WAIT;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_WAIT: begin
          if (abort) begin
            cnt   <= CNT_W'(GAP_CYCLES - 1);
            state <= S_GAP;
          end else if (cnt == '0) begin
            state <= S_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // An abort wins over a word completing on the same edge: that word is dropped.
        S_DATA: begin
          if (abort) begin
            cnt   <= CNT_W'(GAP_CYCLES - 1);
            state <= S_GAP;
          end else begin
            shreg   <= {shreg[7:0], data_pins};
            nib_cnt <= nib_cnt + 1'b1;
            if (nib_cnt == 2'd3) begin
              out_valid <= 1'b1;
              out_data  <= {shreg, data_pins};
              out_addr  <= word_addr;
              out_last  <= (word_idx == len_q);
              word_addr <= word_addr + 16'd1;
              word_idx  <= word_idx + 1'b1;
              if (word_idx == len_q) begin
                cnt   <= CNT_W'(GAP_CYCLES - 1);
                state <= S_GAP;
              end
            end
          end
        end

        S_GAP: begin
          if (cnt == '0) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          addr_pins <= '0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_ram_reader.sv
// Bench for ext_ram_reader: a serial RAM model answers read commands and a scoreboard
// checks every delivered word, its address, last flag and cycle of arrival.
module tb_ext_ram_reader;

  localparam int RL  = 10;
  localparam int GAP = 2;
  localparam int LB  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_addr;
  logic [LB-1:0] req_len;
  logic          abort;
  logic [3:0]    addr_pins;
  logic [3:0]    data_pins;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [15:0]   out_addr;
  logic          out_last;
  logic          busy;

  ext_ram_reader #(
    .READ_LATENCY(RL),
    .GAP_CYCLES  (GAP),
    .MAX_LEN_BITS(LB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .abort    (abort),
    .addr_pins(addr_pins),
    .data_pins(data_pins),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [15:0] addr;
    logic        last;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    if (a == 16'h1234) return 16'hBEEF;
    return {a[7:0] ^ 8'h5A, a[15:8] + 8'h3C};
  endfunction

  // Serial RAM: after a read command and four address nibbles it streams consecutive
  // words, MSB nibble first, starting RL cycles after the last address nibble.
  initial begin : ram_model
    int          phase;
    int          k;
    int          t;
    int          c4;
    int          j;
    logic [15:0] base;
    logic [15:0] w;
    phase = 0;
    k = 0;
    t = 0;
    c4 = 0;
    base = '0;
    data_pins = 4'h0;
    forever begin
      @(negedge clk);
      t++;
      if (!rst_n) begin
        phase = 0;
        data_pins = 4'h0;
      end else if (phase == 1) begin
        base = {base[11:0], addr_pins};
        k++;
        if (k == 4) begin
          phase = 2;
          c4 = t;
        end
      end else if (addr_pins == 4'h1) begin
        phase = 1;
        k = 0;
        data_pins = 4'h0;
      end else if (phase == 2) begin
        j = t - (c4 + RL);
        if (j >= 0) begin
          w = ram_word(base + 16'(j / 4));
          data_pins = w[15 - 4 * (j % 4) -: 4];
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_addr", 32'(out_addr), 32'(e.addr));
          check("out_last", 32'(out_last), 32'(e.last));
          check("out_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  task automatic push_burst(input logic [15:0] a, input int len, input int n0, input int words);
    exp_t e;
    for (int i = 0; i < words; i++) begin
      e.addr = a + 16'(i);
      e.data = ram_word(e.addr);
      e.last = (i == len);
      e.at   = n0 + 8 + RL + 4 * i;
      exp_q.push_back(e);
    end
  endtask

  // Leaves the caller at the negedge of the CMD cycle and returns that cycle number.
  task automatic issue(input logic [15:0] a, input int len, input logic ab, output int n0);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("issue_timeout", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = LB'(len);
    abort     = ab;
    @(negedge clk);
    n0 = cyc;
    req_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(guard < 500), 32'h1);
  endtask

  initial begin : stimulus
    int n0;
    int tt;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    abort     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr_pins", 32'(addr_pins), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_out_data", 32'(out_data), 32'h0);

    // Single word read with the command/address nibble sequence on the pins
    issue(16'h1234, 0, 1'b0, n0);
    push_burst(16'h1234, 0, n0, 1);
    check("single_cmd", 32'(addr_pins), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_ready", 32'(req_ready), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("single_addr_nibble", 32'(addr_pins), 32'(i));
    end
    @(negedge clk);
    check("single_wait_pins", 32'(addr_pins), 32'h0);
    drain();

    // Burst crossing the 16-bit address wrap
    issue(16'hFFFE, 3, 1'b0, n0);
    push_burst(16'hFFFE, 3, n0, 4);
    drain();

    // Abort in DATA after six nibbles: only the first word survives
    issue(16'h2000, 3, 1'b0, n0);
    push_burst(16'h2000, 3, n0, 1);
    repeat (10 + RL) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_gap_pins", 32'(addr_pins), 32'h0);
    check("abort_gap_busy", 32'(busy), 32'h1);
    repeat (GAP - 1) @(negedge clk);
    check("abort_gap_end_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("abort_idle_ready", 32'(req_ready), 32'h1);
    check("abort_idle_busy", 32'(busy), 32'h0);
    check("abort_queue", 32'(exp_q.size()), 32'h0);
    issue(16'h3000, 0, 1'b0, n0);
    push_burst(16'h3000, 0, n0, 1);
    drain();

    // req_valid held high: back-to-back bursts, GAP+1 idle pin cycles between them
    tt = 1 + 4 + (RL - 1) + 4 * 2 + GAP + 1;
    req_addr  = 16'h0100;
    req_len   = LB'(1);
    req_valid = 1'b1;
    @(negedge clk);
    n0 = cyc;
    push_burst(16'h0100, 1, n0, 2);
    push_burst(16'h0100, 1, n0 + tt, 2);
    repeat (tt - GAP - 2) @(negedge clk);
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      check("b2b_gap_pins", 32'(addr_pins), 32'h0);
      check("b2b_gap_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    check("b2b_idle_pins", 32'(addr_pins), 32'h0);
    check("b2b_idle_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_cmd", 32'(addr_pins), 32'h1);
    check("b2b_second_cycle", 32'(cyc), 32'(n0 + tt));
    drain();

    // Asynchronous reset during WAIT discards the burst
    issue(16'h4000, 1, 1'b0, n0);
    push_burst(16'h4000, 1, n0, 2);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_addr_pins", 32'(addr_pins), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_out_data", 32'(out_data), 32'h0);
    check("arst_out_addr", 32'(out_addr), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_ready", 32'(req_ready), 32'h1);

    // Abort together with an accepted request in IDLE is ignored
    issue(16'h0010, 2, 1'b1, n0);
    push_burst(16'h0010, 2, n0, 3);
    check("idle_abort_cmd", 32'(addr_pins), 32'h1);
    drain();
    check("final_queue", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
